// File: rtl/modulus_pkg.sv
// Shared constants and types for the modulus estimator and its scheduler.
package modulus_pkg;

    // ivalid -> ovalid latency of the modulus estimator
    localparam int MODULUS_LAT    = 3;
    // Handshake -> earliest out_valid latency of modulus_sched
    localparam int SCHED_LAT      = 5;
    // Smallest output FIFO that covers the in-flight window plus one
    localparam int FIFO_DEPTH_MIN = 5;

    // Channel tag wide enough for the largest supported requester count (16)
    localparam int CH_TAG_W = 4;
    typedef logic [CH_TAG_W-1:0] ch_tag_t;

endpackage

// File: rtl/modulus.sv
// Magnitude estimator |z| ~= max(|i|,|q|) + min(|i|,|q|)/4.
// Fixed 3-cycle, non-stallable pipeline; the sum wraps mod 2^WIDTH.
module modulus
    import modulus_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ivalid,
    input  logic signed [WIDTH-1:0] i,
    input  logic signed [WIDTH-1:0] q,
    output logic                    ovalid,
    output logic        [WIDTH-1:0] omod
);

    logic [MODULUS_LAT:1] vld_pipe;
    logic [WIDTH-1:0]     abs_i, abs_q, mag_max, mag_min, mag_sum;

    // Valid bit follows the data through the three stages
    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[MODULUS_LAT-1:1], ivalid};
    end

    // Stage 1 abs (most-negative input maps to 2^(WIDTH-1) unsigned),
    // stage 2 max/min sort, stage 3 max + min/4
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            abs_i   <= '0;
            abs_q   <= '0;
            mag_max <= '0;
            mag_min <= '0;
            mag_sum <= '0;
        end else begin
            abs_i   <= i[WIDTH-1] ? -i : i;
            abs_q   <= q[WIDTH-1] ? -q : q;
            mag_max <= (abs_i > abs_q) ? abs_i : abs_q;
            mag_min <= (abs_i > abs_q) ? abs_q : abs_i;
            mag_sum <= mag_max + (mag_min >> 2);
        end
    end

    assign ovalid = vld_pipe[MODULUS_LAT];
    assign omod   = mag_sum;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request found after
// last_grant (wrapping), or no grant when disabled or nothing requested.
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic           en,
    input  logic [CHW-1:0] last_grant,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_idx
);

    logic found;

    // Walk the priority order last_grant+1, +2, ... and take the first hit
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < NCH; k++) begin
                if (en && !found && req[k] &&
                    ((int'(last_grant) + 1 + n) % NCH) == k) begin
                    grant[k]  = 1'b1;
                    grant_idx = CHW'(k);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/modulus_sched.sv
// Round-robin scheduler sharing one modulus estimator between NCH I/Q
// requesters. Results are tagged with their channel and buffered in an
// output FIFO; issue is credit-limited so the non-stallable estimator can
// never overrun the FIFO.
// Optional: define MODULUS_SCHED_STATS_EN to add saturating stat_issue /
// stat_stall counters.
module modulus_sched
    import modulus_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int NCH        = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int CHW        = $clog2(NCH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH-1:0]       req_valid,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH*WIDTH-1:0] req_i,
    input  logic [NCH*WIDTH-1:0] req_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mod,
    output logic [CHW-1:0]       out_ch,
    output logic                 busy
`ifdef MODULUS_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issue,
    output logic [31:0]          stat_stall
`endif
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [FIFO_AW-1:0] LAST_SLOT = FIFO_AW'(FIFO_DEPTH - 1);

    logic [2:0]              inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0]        fifo_mod [FIFO_DEPTH];
    logic [CHW-1:0]          fifo_ch  [FIFO_DEPTH];

    logic                    credit_ok, handshake, push, pop;
    logic [NCH-1:0]          grant;
    logic [CHW-1:0]          grant_idx, last_grant;
    logic signed [WIDTH-1:0] sel_i, sel_q;

    logic                    iss_valid;
    logic signed [WIDTH-1:0] iss_i, iss_q;
    logic [CHW-1:0]          iss_ch;
    logic [MODULUS_LAT-1:0][CHW-1:0] tag_pipe;

    logic                    mod_valid;
    logic [WIDTH-1:0]        mod_val;

    // Everything issued but not yet written counts against FIFO space
    assign credit_ok = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req        (req_valid),
        .en         (credit_ok & ~reset),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    // Select the granted lane's sample
    always_comb begin
        sel_i = '0;
        sel_q = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                sel_i = req_i[k*WIDTH +: WIDTH];
                sel_q = req_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Issue register feeding the estimator; last_grant starts at NCH-1 so
    // channel 0 has first priority out of reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iss_valid  <= 1'b0;
            iss_i      <= '0;
            iss_q      <= '0;
            iss_ch     <= '0;
            last_grant <= CHW'(NCH - 1);
        end else begin
            iss_valid <= handshake;
            if (handshake) begin
                iss_i      <= sel_i;
                iss_q      <= sel_q;
                iss_ch     <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    modulus #(.WIDTH(WIDTH)) u_modulus (
        .clock  (clock),
        .reset  (reset),
        .ivalid (iss_valid),
        .i      (iss_i),
        .q      (iss_q),
        .ovalid (mod_valid),
        .omod   (mod_val)
    );

    // Channel tag line, shifted every cycle to stay aligned with the estimator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tag_pipe <= '0;
        else       tag_pipe <= {tag_pipe[MODULUS_LAT-2:0], iss_ch};
    end

    // Samples between handshake and FIFO write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({handshake, mod_valid})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign push = mod_valid;
    assign pop  = out_valid & out_ready;

    // FIFO pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mod[wr_ptr] <= mod_val;
            fifo_ch[wr_ptr]  <= tag_pipe[MODULUS_LAT-1];
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_mod   = out_valid ? fifo_mod[rd_ptr] : '0;
    assign out_ch    = out_valid ? fifo_ch[rd_ptr]  : '0;
    assign busy      = (inflight != '0) || out_valid;

`ifdef MODULUS_SCHED_STATS_EN
    // Saturating counters: accepted samples, and cycles starved of credit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (handshake && stat_issue != '1)
                stat_issue <= stat_issue + 32'd1;
            if ((|req_valid) && !credit_ok && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
